// File: rtl/ul_ram_wr_control.sv
// ---------------------------------------------------------------------------
// ul_ram_wr_control
// Write-side controller for the uplink ping-pong frame RAM. Uplink words from
// the framing logic are written into one of two banks (bank 0 at
// BANK0_BASE.., bank 1 at BANK1_BASE..). A bank that holds a complete frame is
// flagged full on UlRAM_wr_state until the read controller hands it back on
// UlRAM_rd_state. Frames aimed at a full bank are dropped and counted.
//
// Ports
//   clk             system clock
//   nRst            asynchronous active-low reset
//   dinEn           input word valid, one word per cycle
//   din             input word
//   sofIn           start-of-frame flag, qualified by dinEn
//   UlRAM_rd_state  per-bank "read out" flags from the read controller
//   UlRAM_wr_state  per-bank "full, unread" flags to the read controller
//   wrRAMEn         RAM write enable
//   wrRAMAddr       RAM write address
//   wrRAMData       RAM write data
//   frameErr        one-cycle pulse: current frame aborted by an early SOF
//   frameDrop       one-cycle pulse: frame dropped because its bank was full
//   dropCnt         saturating count of dropped frames
// ---------------------------------------------------------------------------
module ul_ram_wr_control #(
  parameter int         FRAME_LEN  = 262,
  parameter logic [9:0] BANK0_BASE = 10'd0,
  parameter logic [9:0] BANK1_BASE = 10'd512,
  parameter int         DATA_W     = 10
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              dinEn,
  input  logic [DATA_W-1:0] din,
  input  logic              sofIn,
  input  logic [1:0]        UlRAM_rd_state,
  output logic [1:0]        UlRAM_wr_state,
  output logic              wrRAMEn,
  output logic [9:0]        wrRAMAddr,
  output logic [DATA_W-1:0] wrRAMData,
  output logic              frameErr,
  output logic              frameDrop,
  output logic [7:0]        dropCnt
);

  localparam logic [8:0] LAST_IDX = 9'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_DROP
  } state_t;

  state_t     state;
  logic [8:0] idx;
  logic       bank;
  logic [1:0] rd_s;

  function automatic logic [9:0] word_addr(input logic b, input logic [8:0] i);
    return (b ? BANK1_BASE : BANK0_BASE) + {1'b0, i};
  endfunction

  // Single FSM block: all outputs are registered here. A SOF in any state
  // starts a new frame against the current target bank; a non-SOF word only
  // matters while a frame (written or dropped) is in progress.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state          <= S_IDLE;
      idx            <= '0;
      bank           <= 1'b0;
      rd_s           <= '0;
      UlRAM_wr_state <= '0;
      wrRAMEn        <= 1'b0;
      wrRAMAddr      <= '0;
      wrRAMData      <= '0;
      frameErr       <= 1'b0;
      frameDrop      <= 1'b0;
      dropCnt        <= '0;
    end else begin
      wrRAMEn   <= 1'b0;
      frameErr  <= 1'b0;
      frameDrop <= 1'b0;

      // Release path: the reader's flag is registered once, and the full flag
      // drops on the cycle after that registered copy is seen high. The bank
      // being written is never full, so the set below never hits a bit that
      // is being cleared here.
      rd_s <= UlRAM_rd_state;
      for (int n = 0; n < 2; n++) begin
        if (rd_s[n]) UlRAM_wr_state[n] <= 1'b0;
      end

      case (state)
        S_IDLE, S_WR, S_DROP: begin
          if (dinEn && sofIn) begin
            idx <= 9'd1;
            if (state == S_WR) frameErr <= 1'b1;
            if (UlRAM_wr_state[bank]) begin
              // Bank still unread: consume the frame without writing. The
              // target bank stays put so frames reach the reader in order.
              frameDrop <= 1'b1;
              if (dropCnt != 8'hFF) dropCnt <= dropCnt + 8'd1;
              state <= S_DROP;
            end else begin
              wrRAMEn   <= 1'b1;
              wrRAMAddr <= word_addr(bank, 9'd0);
              wrRAMData <= din;
              state     <= S_WR;
            end
          end else if (dinEn && (state != S_IDLE)) begin
            if (state == S_WR) begin
              wrRAMEn   <= 1'b1;
              wrRAMAddr <= word_addr(bank, idx);
              wrRAMData <= din;
            end
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= S_IDLE;
              if (state == S_WR) begin
                UlRAM_wr_state[bank] <= 1'b1;
                bank                 <= ~bank;
              end
            end else begin
              idx <= idx + 9'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule
